hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage core. Drives enable/flush of the PC, IF/ID, ID/EX,
//  EX/MEM and MEM/WB registers (id_ex_reg et al.). Resolves load-use hazards, multi-cycle
//  mul/div occupancy of EX, data-memory wait states and taken-branch squashes.

---
 rtl/hazard_ctrl_pkg.sv | 57 +++++
 rtl/hazard_ctrl_if.sv | 46 ++++
 rtl/hazard_ctrl_sat_counter.sv | 30 +++
 rtl/hazard_ctrl.sv | 117 +++++++++++
 tb/tb_hazard_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared types and constants for the pipeline hazard sequencer
//
// Purpose: register-index type, sequencer state enum, per-stage control bundle,
//          NOP encoding, multi-cycle defaults and the load-use detect helper.
// Ports:   none (package).
package hazard_ctrl_pkg;

    typedef logic [4:0] r_t;

    typedef enum logic {
        RUN    = 1'b0,
        MULDIV = 1'b1
    } hz_state_t;

    // Enable/flush for every pipeline register, in pipeline order.
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_flush;
        logic ex_mem_en;
        logic ex_mem_flush;
        logic mem_wb_en;
    } ctrl_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int MUL_CYCLES_DEF = 3;
    localparam int DIV_CYCLES_DEF = 33;

    localparam ctrl_t CTRL_RUN      = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0,
                                        id_ex_en: 1'b1, id_ex_flush: 1'b0, ex_mem_en: 1'b1,
                                        ex_mem_flush: 1'b0, mem_wb_en: 1'b1};
    localparam ctrl_t CTRL_HOLD     = '{default: 1'b0};
    // EX is occupied: freeze the front end, keep a bubble flowing into EX/MEM
    // so MEM/WB can drain the older instructions.
    localparam ctrl_t CTRL_MULDIV   = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
                                        id_ex_en: 1'b0, id_ex_flush: 1'b0, ex_mem_en: 1'b1,
                                        ex_mem_flush: 1'b1, mem_wb_en: 1'b1};
    localparam ctrl_t CTRL_BRANCH   = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1,
                                        id_ex_en: 1'b1, id_ex_flush: 1'b1, ex_mem_en: 1'b1,
                                        ex_mem_flush: 1'b0, mem_wb_en: 1'b1};
    localparam ctrl_t CTRL_LOAD_USE = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
                                        id_ex_en: 1'b1, id_ex_flush: 1'b1, ex_mem_en: 1'b1,
                                        ex_mem_flush: 1'b0, mem_wb_en: 1'b1};

    // x0 is hardwired to zero, so a load targeting it can never create a hazard.
    function automatic logic load_use_hit(input logic is_load, input r_t rd,
                                          input r_t rs1, input logic use_rs1,
                                          input r_t rs2, input logic use_rs2);
        return is_load && (rd != 5'd0) &&
               ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline <-> hazard sequencer signal bundle
//
// Purpose: groups the ID/EX/MEM status inputs and the per-register control outputs.
// Modports:
//   master - pipeline side: drives status, receives enables/flushes and stall count
//   slave  - hazard_ctrl side
interface hazard_ctrl_if;
    import hazard_ctrl_pkg::*;

    r_t          id_rs1;
    r_t          id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    r_t          ex_rd;
    logic        ex_is_load;
    logic        ex_mul;
    logic        ex_div;
    logic        branch_taken;
    logic        dmem_busy;

    logic        pc_en;
    logic        if_id_en;
    logic        if_id_flush;
    logic        id_ex_en;
    logic        id_ex_flush;
    logic        ex_mem_en;
    logic        ex_mem_flush;
    logic        mem_wb_en;
    logic        muldiv_busy;
    logic [31:0] stall_cycles;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
               ex_mul, ex_div, branch_taken, dmem_busy,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
               ex_mem_en, ex_mem_flush, mem_wb_en, muldiv_busy, stall_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
               ex_mul, ex_div, branch_taken, dmem_busy,
        output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
               ex_mem_en, ex_mem_flush, mem_wb_en, muldiv_busy, stall_cycles
    );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// rtl/hazard_ctrl_sat_counter.sv - saturating up-counter
//
// Purpose: counts cycles with inc=1, sticks at all-ones instead of wrapping.
// Ports:
//   clk   in  1      clock, rising edge
//   rst_n in  1      asynchronous active-low reset, clears the count
//   inc   in  1      count this cycle
//   q     out WIDTH  current count
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= '0;
        end else if (inc && (q_r != '1)) begin
            q_r <= q_r + 1'b1;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage pipeline hazard sequencer
//
// Purpose: drives enable/flush of PC, IF/ID, ID/EX, EX/MEM, MEM/WB. Handles
//          load-use bubbles, multi-cycle MUL/DIV occupancy of EX, data-memory
//          wait states and taken-branch squashes; counts stalled cycles.
// Ports:
//   clk    in  1   core clock
//   rst_n  in  1   asynchronous active-low reset
//   bus    slave   hazard_ctrl_if: stage status in, register controls and
//                  muldiv_busy / stall_cycles out
// Controls are combinational from state + inputs (no added latency).
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_ctrl_if.slave  bus
);

    // The entry cycle is the first cycle of occupancy and the release cycle
    // (cnt==0) is the last, hence the -2.
    localparam logic [7:0] MUL_LOAD = 8'(MUL_CYCLES - 2);
    localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 2);

    hz_state_t  state, state_d;
    logic [7:0] cnt, cnt_d;
    ctrl_t      ctrl;
    logic       muldiv_start;
    logic       muldiv_busy;
    logic       load_use;
    logic [31:0] stall_q;

    assign muldiv_start = (state == RUN) && (bus.ex_mul || bus.ex_div) && !bus.dmem_busy;
    assign load_use     = load_use_hit(bus.ex_is_load, bus.ex_rd,
                                       bus.id_rs1, bus.id_use_rs1,
                                       bus.id_rs2, bus.id_use_rs2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= 8'd0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // A memory wait freezes the sequencer entirely so the occupancy count
    // resumes exactly where it left off.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        if (!bus.dmem_busy) begin
            case (state)
                RUN: begin
                    if (bus.ex_mul || bus.ex_div) begin
                        state_d = MULDIV;
                        cnt_d   = bus.ex_div ? DIV_LOAD : MUL_LOAD;
                    end
                end
                MULDIV: begin
                    if (cnt != 8'd0) begin
                        cnt_d = cnt - 8'd1;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // Priority: dmem_busy > mul/div occupancy > branch squash > load-use.
    // While EX holds a mul/div it cannot hold a branch or a load, so those
    // inputs are ignored there.
    always_comb begin
        ctrl        = CTRL_RUN;
        muldiv_busy = muldiv_start || ((state == MULDIV) && (cnt != 8'd0));
        if (bus.dmem_busy) begin
            ctrl = CTRL_HOLD;
        end else if (state == MULDIV) begin
            if (cnt != 8'd0) begin
                ctrl = CTRL_MULDIV;
            end
        end else if (bus.ex_mul || bus.ex_div) begin
            ctrl = CTRL_MULDIV;
        end else if (bus.branch_taken) begin
            ctrl = CTRL_BRANCH;
        end else if (load_use) begin
            ctrl = CTRL_LOAD_USE;
        end
    end

    assign bus.pc_en        = ctrl.pc_en;
    assign bus.if_id_en     = ctrl.if_id_en;
    assign bus.if_id_flush  = ctrl.if_id_flush;
    assign bus.id_ex_en     = ctrl.id_ex_en;
    assign bus.id_ex_flush  = ctrl.id_ex_flush;
    assign bus.ex_mem_en    = ctrl.ex_mem_en;
    assign bus.ex_mem_flush = ctrl.ex_mem_flush;
    assign bus.mem_wb_en    = ctrl.mem_wb_en;
    assign bus.muldiv_busy  = muldiv_busy;
    assign bus.stall_cycles = stall_q;

    sat_counter #(.WIDTH(32)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (!ctrl.pc_en),
        .q     (stall_q)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
    //  ex_mem_en, ex_mem_flush, mem_wb_en, muldiv_busy}
    localparam logic [8:0] E_NORMAL = 9'b1_1_0_1_0_1_0_1_0;
    localparam logic [8:0] E_LDUSE  = 9'b0_0_0_1_1_1_0_1_0;
    localparam logic [8:0] E_BRANCH = 9'b1_1_1_1_1_1_0_1_0;
    localparam logic [8:0] E_HOLD   = 9'b0_0_0_0_0_0_0_0_0;
    localparam logic [8:0] E_MD     = 9'b0_0_0_0_0_1_1_1_1;
    localparam logic [8:0] E_MDWAIT = 9'b0_0_0_0_0_0_0_0_1;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic [4:0] rd;
        logic       load;
        logic       br;
        logic       busy;
        logic [8:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;
    logic [31:0] exp_stall = 32'd0;

    hazard_ctrl_if bus ();

    hazard_ctrl #(.MUL_CYCLES(3), .DIV_CYCLES(33)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.id_rs1 = 5'd0;  bus.id_rs2 = 5'd0;
        bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0;
        bus.ex_rd = 5'd0;   bus.ex_is_load = 1'b0;
        bus.ex_mul = 1'b0;  bus.ex_div = 1'b0;
        bus.branch_taken = 1'b0; bus.dmem_busy = 1'b0;
    endtask

    task automatic chk_ctrl(input string nm, input logic [8:0] exp);
        logic [8:0] act;
        act = {bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_en, bus.id_ex_flush,
               bus.ex_mem_en, bus.ex_mem_flush, bus.mem_wb_en, bus.muldiv_busy};
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: ctrl got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Runs one mul/div from its entry cycle to its release cycle. Optionally
    // injects a dmem wait of busy_len cycles when the occupancy count is busy_at.
    task automatic do_muldiv(input string nm, input bit is_div, input int n_cyc,
                             input int busy_at, input int busy_len,
                             input int exp_low, input int exp_occ);
        int k;
        int low;
        int occ;
        logic [31:0] start;
        start = exp_stall;
        low = 0;
        occ = 0;
        k = n_cyc - 2;
        bus.ex_div = is_div;
        bus.ex_mul = !is_div;
        #3;
        chk_ctrl({nm, "_entry"}, E_MD);
        if (!bus.pc_en) low++;
        occ++;
        exp_stall++;
        tick();
        for (int guard = 0; guard < 300; guard++) begin
            if (k == busy_at && busy_len > 0) begin
                bus.dmem_busy = 1'b1;
                for (int b = 0; b < busy_len; b++) begin
                    #3;
                    chk_ctrl($sformatf("%s_wait%0d", nm, b), E_MDWAIT);
                    if (!bus.pc_en) low++;
                    occ++;
                    exp_stall++;
                    tick();
                end
                bus.dmem_busy = 1'b0;
            end
            if (k == 0) break;
            #3;
            chk_ctrl($sformatf("%s_cnt%0d", nm, k), E_MD);
            if (!bus.pc_en) low++;
            occ++;
            exp_stall++;
            k--;
            tick();
        end
        #3;
        chk_ctrl({nm, "_release"}, E_NORMAL);
        occ++;
        tick();
        bus.ex_div = 1'b0;
        bus.ex_mul = 1'b0;
        chk32({nm, "_pc_low"}, 32'(low), 32'(exp_low));
        chk32({nm, "_occupancy"}, 32'(occ), 32'(exp_occ));
        chk32({nm, "_stall_cycles"}, bus.stall_cycles, start + 32'(exp_low));
    endtask

    initial begin
        vec_t vecs[10];
        //            rs1    rs2    u1    u2    rd     load  br    busy  expected
        vecs[0] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_NORMAL};
        vecs[1] = '{5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, E_LDUSE};
        vecs[2] = '{5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, E_NORMAL};
        vecs[3] = '{5'd5, 5'd9, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, E_LDUSE};
        vecs[4] = '{5'd5, 5'd9, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, E_NORMAL};
        vecs[5] = '{5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, E_NORMAL};
        vecs[6] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, E_BRANCH};
        vecs[7] = '{5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, E_BRANCH};
        vecs[8] = '{5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, E_HOLD};
        vecs[9] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, E_HOLD};

        idle_inputs();

        // Reset held for three cycles
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        #3;
        chk_ctrl("reset_ctrl", E_NORMAL);
        chk32("reset_stall", bus.stall_cycles, 32'd0);
        tick();

        // Single-cycle vectors in RUN
        for (int i = 0; i < 10; i++) begin
            bus.id_rs1 = vecs[i].rs1;       bus.id_rs2 = vecs[i].rs2;
            bus.id_use_rs1 = vecs[i].use1;  bus.id_use_rs2 = vecs[i].use2;
            bus.ex_rd = vecs[i].rd;         bus.ex_is_load = vecs[i].load;
            bus.branch_taken = vecs[i].br;  bus.dmem_busy = vecs[i].busy;
            #3;
            chk_ctrl($sformatf("vec%0d", i), vecs[i].exp);
            if (!vecs[i].exp[8]) exp_stall++;
            tick();
        end
        idle_inputs();
        chk32("vec_stall_cycles", bus.stall_cycles, 32'd4);

        // DIV: 32 stalled cycles then release, 33 cycles of EX occupancy
        do_muldiv("div", 1'b1, 33, -1, 0, 32, 33);
        // MUL: 2 stalled cycles
        do_muldiv("mul", 1'b0, 3, -1, 0, 2, 3);
        // DIV with a 4-cycle memory wait at cnt=10: occupancy 37
        do_muldiv("div_wait", 1'b1, 33, 10, 4, 36, 37);

        // Asynchronous reset in the middle of a MUL
        bus.ex_mul = 1'b1;
        tick();
        #1;
        chk_ctrl("mul_before_reset", E_MD);
        rst_n = 1'b0;
        bus.ex_mul = 1'b0;
        #1;
        chk_ctrl("async_reset_ctrl", E_NORMAL);
        chk32("async_reset_stall", bus.stall_cycles, 32'd0);
        exp_stall = 32'd0;
        tick();
        rst_n = 1'b1;
        tick();
        do_muldiv("mul_after_reset", 1'b0, 3, -1, 0, 2, 3);

        // Saturation of the stall counter
        force dut.u_stall_cnt.q_r = 32'hFFFF_FFFE;
        #1;
        release dut.u_stall_cnt.q_r;
        bus.dmem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk32($sformatf("sat_stall%0d", i), bus.stall_cycles, 32'hFFFF_FFFF);
        end
        bus.dmem_busy = 1'b0;
        tick();
        chk32("sat_hold", bus.stall_cycles, 32'hFFFF_FFFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
